cfg_lut_bank: RTL

//   Bank of NUM_LUT independent K-input lookup tables, each a 2**K-bit truth table

---
 rtl/cfg_lut_bank_if.sv | 37 +++
 rtl/cfg_lut_bank.sv | 121 ++++++++++++
 2 files changed

// File: rtl/cfg_lut_bank_if.sv
// Loader and lookup bundle for cfg_lut_bank.
// master drives requests, slave is the LUT bank.
interface cfg_lut_bank_if #(
  parameter int K       = 4,
  parameter int NUM_LUT = 2
);
  localparam int SEL_W = (NUM_LUT > 1) ? $clog2(NUM_LUT) : 1;

  logic               cfg_start;
  logic [SEL_W-1:0]   cfg_sel;
  logic               cfg_abort;
  logic               cfg_valid;
  logic               cfg_bit;
  logic               cfg_ready;
  logic               cfg_busy;
  logic               cfg_done;
  logic               in_valid;
  logic [NUM_LUT*K-1:0] in_addr;
  logic               out_valid;
  logic [NUM_LUT-1:0] out_f;

  modport master (
    output cfg_start, cfg_sel, cfg_abort,
    output cfg_valid, cfg_bit,
    output in_valid, in_addr,
    input  cfg_ready, cfg_busy, cfg_done,
    input  out_valid, out_f
  );

  modport slave (
    input  cfg_start, cfg_sel, cfg_abort,
    input  cfg_valid, cfg_bit,
    input  in_valid, in_addr,
    output cfg_ready, cfg_busy, cfg_done,
    output out_valid, out_f
  );
endinterface

// File: rtl/cfg_lut_bank.sv
// Bank of runtime-programmable K-input LUTs with a serial
// loader and a registered, single-cycle parallel lookup.
module cfg_lut_bank #(
  parameter int K       = 4,
  parameter int NUM_LUT = 2
) (
  input logic           clk,
  input logic           rst,
  cfg_lut_bank_if.slave bus
);
  localparam int DEPTH = 1 << K;
  localparam int SEL_W = (NUM_LUT > 1) ? $clog2(NUM_LUT) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [SEL_W-1:0]   sel;
  logic [DEPTH-1:0]   shadow;
  logic [DEPTH-1:0]   tbl [NUM_LUT];
  logic               ready_q;
  logic               busy_q;
  logic               done_q;
  logic               ov_q;
  logic [NUM_LUT-1:0] of_q;
  logic               sel_ok;
  logic               last;

  assign sel_ok = int'(bus.cfg_sel) < NUM_LUT;
  assign last   = cnt == CW'(DEPTH - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sel     <= '0;
      shadow  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.cfg_start && sel_ok) begin
            state   <= LOAD;
            sel     <= bus.cfg_sel;
            cnt     <= '0;
            shadow  <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          // abort wins over a bit arriving in the same cycle
          if (bus.cfg_abort) begin
            state   <= IDLE;
            cnt     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (bus.cfg_valid) begin
            shadow[cnt[CW-2:0]] <= bus.cfg_bit;
            cnt <= cnt + 1'b1;
            if (last) begin
              state   <= COMMIT;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        COMMIT: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NUM_LUT; j++) begin
        tbl[j] <= '0;
      end
    end else if (state == COMMIT) begin
      tbl[sel] <= shadow;
    end
  end

  // reads see the table as it was before this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q <= 1'b0;
      of_q <= '0;
    end else begin
      ov_q <= bus.in_valid;
      if (bus.in_valid) begin
        for (int j = 0; j < NUM_LUT; j++) begin
          of_q[j] <= tbl[j][bus.in_addr[j*K +: K]];
        end
      end
    end
  end

  assign bus.cfg_ready = ready_q;
  assign bus.cfg_busy  = busy_q;
  assign bus.cfg_done  = done_q;
  assign bus.out_valid = ov_q;
  assign bus.out_f     = of_q;
endmodule
